// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte requesters.
// Launches one byte per grant, tracks tx_idle for frame accept/complete, flags lost launches.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int bit_n       = 8,
  parameter int ACK_TIMEOUT = 4,
  localparam int GW         = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*bit_n-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic                     tx_data_rdy,
  output logic [bit_n-1:0]         tx_data,
  input  logic                     tx_idle,
  output logic                     busy,
  output logic [GW-1:0]            grant_id,
  output logic                     err_timeout,
  output logic [15:0]              frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_SEND} state_t;

  state_t               r_state;
  logic [GW-1:0]        r_ptr;
  logic [7:0]           r_cnt;
  logic [NUM_REQ-1:0]   r_req_ack;
  logic                 r_tx_data_rdy;
  logic [bit_n-1:0]     r_tx_data;
  logic                 r_busy;
  logic [GW-1:0]        r_grant_id;
  logic                 r_err_timeout;
  logic [15:0]          r_frame_cnt;

  logic                 w_found;
  logic [GW-1:0]        w_sel;
  logic [GW:0]          w_sum;
  logic [GW-1:0]        w_ptr_nxt;

  // Search starts at r_ptr and wraps; the first set request encountered wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(NUM_REQ))
        w_sum = w_sum - (GW+1)'(NUM_REQ);
      if (!w_found && req[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[GW-1:0];
      end
    end
  end

  assign w_ptr_nxt = (r_grant_id == GW'(NUM_REQ-1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_req_ack     <= '0;
      r_tx_data_rdy <= 1'b0;
      r_tx_data     <= '0;
      r_busy        <= 1'b0;
      r_grant_id    <= '0;
      r_err_timeout <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_req_ack     <= '0;
      r_tx_data_rdy <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_idle && w_found) begin
            r_tx_data     <= req_data[w_sel*bit_n +: bit_n];
            r_grant_id    <= w_sel;
            r_req_ack     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
            r_tx_data_rdy <= 1'b1;
            r_cnt         <= '0;
            r_busy        <= 1'b1;
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt <= r_cnt + 8'd1;
          if (!tx_idle) begin
            r_state <= S_SEND;
          end else if (r_cnt == 8'(ACK_TIMEOUT-1)) begin
            // Transmitter never took the byte: drop it and move the turn on.
            r_err_timeout <= 1'b1;
            r_ptr         <= w_ptr_nxt;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        S_SEND: begin
          if (tx_idle) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_ptr       <= w_ptr_nxt;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack     = r_req_ack;
  assign tx_data_rdy = r_tx_data_rdy;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;
  assign err_timeout = r_err_timeout;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model plus a grant scoreboard of (requester, byte).
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int BW = 8;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*BW-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic            tx_data_rdy;
  logic [BW-1:0]   tx_data;
  logic            tx_idle;
  logic            busy;
  logic [1:0]      grant_id;
  logic            err_timeout;
  logic [15:0]     frame_cnt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .bit_n(BW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_ack(req_ack),
    .tx_data_rdy(tx_data_rdy), .tx_data(tx_data), .tx_idle(tx_idle), .busy(busy),
    .grant_id(grant_id), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  // Transmitter model: idle drops m_drop cycles after a launch, returns m_len cycles later.
  logic model_idle = 1'b1;
  bit   hold_busy  = 1'b0;
  bit   m_never    = 1'b0;
  int   m_drop     = 2;
  int   m_len      = 40;
  int   m_phase    = 0;
  int   m_cnt      = 0;

  assign tx_idle = model_idle & ~hold_busy;

  always @(negedge clk) begin
    case (m_phase)
      0: if (tx_data_rdy && !m_never) begin m_phase = 1; m_cnt = m_drop; end
      1: begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin model_idle = 1'b0; m_phase = 2; m_cnt = m_len; end
      end
      default: begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin model_idle = 1'b1; m_phase = 0; end
      end
    endcase
  end

  typedef struct {int id; logic [BW-1:0] dat;} exp_t;
  exp_t          sb[$];
  exp_t          e;
  logic [N-1:0]  ea;
  bit            got;
  int            extra;
  int            checks = 0;
  int            errors = 0;

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_not_busy(input int budget, output bit ok, output int n_extra);
    ok = 1'b0; n_extra = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ack != '0 || tx_data_rdy) n_extra++;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    req = '0; hold_busy = 1'b0; m_never = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req = '0; req_data = '0; rst_n = 1'b0;
    #1;
    checks++; if (req_ack !== 4'h0)       begin errors++; $display("FAIL rst_ack: got %b expected 0", req_ack); end
    checks++; if (tx_data_rdy !== 1'b0)   begin errors++; $display("FAIL rst_rdy: got %b expected 0", tx_data_rdy); end
    checks++; if (tx_data !== 8'h00)      begin errors++; $display("FAIL rst_data: got %h expected 00", tx_data); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 2'd0)      begin errors++; $display("FAIL rst_gid: got %0d expected 0", grant_id); end
    checks++; if (err_timeout !== 1'b0)   begin errors++; $display("FAIL rst_err: got %b expected 0", err_timeout); end
    checks++; if (frame_cnt !== 16'h0)    begin errors++; $display("FAIL rst_fcnt: got %h expected 0", frame_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    m_len = 40;
    req_data[7:0] = 8'hA5; sb.push_back('{0, 8'hA5}); req = 4'b0001;
    wait_ack(50, got);
    checks++; if (!got) begin errors++; $display("FAIL single_ack_wait: got none expected ack"); end
    if (got) begin
      e = sb.pop_front(); ea = '0; ea[e.id] = 1'b1; req = '0;
      checks++; if (req_ack !== ea)      begin errors++; $display("FAIL single_ack: got %b expected %b", req_ack, ea); end
      checks++; if (tx_data_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b expected 1", tx_data_rdy); end
      checks++; if (tx_data !== e.dat)   begin errors++; $display("FAIL single_data: got %h expected %h", tx_data, e.dat); end
      checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
      @(negedge clk);
      checks++; if (req_ack !== 4'h0 || tx_data_rdy !== 1'b0)
        begin errors++; $display("FAIL single_pulse: got ack %b rdy %b expected 0 0", req_ack, tx_data_rdy); end
    end
    wait_not_busy(200, got, extra);
    checks++; if (!got || extra != 0) begin errors++; $display("FAIL single_done: got done %0d extra %0d expected 1 0", got, extra); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_fcnt: got %0d expected 1", frame_cnt); end
    checks++; if (tx_data !== 8'hA5)   begin errors++; $display("FAIL single_hold: got %h expected a5", tx_data); end
  endtask

  task automatic test_round_robin();
    int pushed;
    do_reset(); m_len = 5;
    for (int i = 0; i < N; i++) begin
      req_data[i*BW +: BW] = 8'(8'h10 + i); sb.push_back('{i, 8'(8'h10 + i)});
    end
    pushed = N; req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      wait_ack(100, got);
      checks++; if (!got) begin errors++; $display("FAIL rr_wait: got none expected grant %0d", g); end
      if (!got) break;
      e = sb.pop_front(); ea = '0; ea[e.id] = 1'b1;
      checks++; if (req_ack !== ea)        begin errors++; $display("FAIL rr_ack: got %b expected %b", req_ack, ea); end
      checks++; if (grant_id !== 2'(e.id)) begin errors++; $display("FAIL rr_gid: got %0d expected %0d", grant_id, e.id); end
      checks++; if (tx_data !== e.dat)     begin errors++; $display("FAIL rr_data: got %h expected %h", tx_data, e.dat); end
      req_data[e.id*BW +: BW] = 8'(8'h20 + e.id);
      if (pushed < 6) begin sb.push_back('{e.id, 8'(8'h20 + e.id)}); pushed++; end
    end
    req = '0;
    wait_not_busy(100, got, extra);
    checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL rr_fcnt: got %0d expected 6", frame_cnt); end
    sb.delete();
  endtask

  task automatic test_fairness();
    do_reset();
    req_data = {8'h63, 8'hEE, 8'h61, 8'hEE};
    for (int r = 0; r < 2; r++) begin sb.push_back('{1, 8'h61}); sb.push_back('{3, 8'h63}); end
    req = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      wait_ack(100, got);
      checks++; if (!got) begin errors++; $display("FAIL fair_wait: got none expected grant %0d", g); end
      if (!got) break;
      e = sb.pop_front(); ea = '0; ea[e.id] = 1'b1;
      checks++; if (req_ack !== ea)        begin errors++; $display("FAIL fair_ack: got %b expected %b", req_ack, ea); end
      checks++; if (grant_id !== 2'(e.id)) begin errors++; $display("FAIL fair_gid: got %0d expected %0d", grant_id, e.id); end
      checks++; if (tx_data !== e.dat)     begin errors++; $display("FAIL fair_data: got %h expected %h", tx_data, e.dat); end
    end
    req = '0;
    wait_not_busy(100, got, extra);
    sb.delete();
  endtask

  task automatic test_timeout();
    int n_err;
    do_reset(); m_never = 1'b1;
    req_data[7:0] = 8'h3C; sb.push_back('{0, 8'h3C}); req = 4'b0001;
    wait_ack(50, got);
    checks++; if (!got) begin errors++; $display("FAIL to_wait: got none expected ack"); end
    if (got) begin
      e = sb.pop_front(); ea = '0; ea[e.id] = 1'b1;
      checks++; if (req_ack !== ea) begin errors++; $display("FAIL to_ack: got %b expected %b", req_ack, ea); end
    end
    req = '0; n_err = 0;
    repeat (TO + 16) begin @(negedge clk); if (err_timeout === 1'b1) n_err++; end
    checks++; if (n_err != 1)          begin errors++; $display("FAIL to_pulse: got %0d pulses expected 1", n_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL to_fcnt: got %0d expected 0", frame_cnt); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
    m_never = 1'b0;
    req_data[15:8] = 8'h4B; sb.push_back('{1, 8'h4B}); req = 4'b0011;
    wait_ack(50, got);
    checks++; if (!got) begin errors++; $display("FAIL to_next_wait: got none expected ack"); end
    if (got) begin
      e = sb.pop_front(); ea = '0; ea[e.id] = 1'b1;
      checks++; if (req_ack !== ea)    begin errors++; $display("FAIL to_next_ack: got %b expected %b", req_ack, ea); end
      checks++; if (tx_data !== e.dat) begin errors++; $display("FAIL to_next_data: got %h expected %h", tx_data, e.dat); end
    end
    req = '0;
    wait_not_busy(200, got, extra);
  endtask

  task automatic test_busy_start();
    int n_act;
    hold_busy = 1'b1;
    req_data[23:16] = 8'h5A; sb.push_back('{2, 8'h5A}); req = 4'b0100;
    n_act = 0;
    repeat (10) begin @(negedge clk); if (req_ack != '0 || tx_data_rdy || busy) n_act++; end
    checks++; if (n_act != 0) begin errors++; $display("FAIL bs_quiet: got %0d active cycles expected 0", n_act); end
    hold_busy = 1'b0;
    wait_ack(20, got);
    checks++; if (!got) begin errors++; $display("FAIL bs_wait: got none expected ack"); end
    if (got) begin
      e = sb.pop_front(); ea = '0; ea[e.id] = 1'b1;
      checks++; if (req_ack !== ea)        begin errors++; $display("FAIL bs_ack: got %b expected %b", req_ack, ea); end
      checks++; if (grant_id !== 2'(e.id)) begin errors++; $display("FAIL bs_gid: got %0d expected %0d", grant_id, e.id); end
      checks++; if (tx_data !== e.dat)     begin errors++; $display("FAIL bs_data: got %h expected %h", tx_data, e.dat); end
    end
    req = '0;
    wait_not_busy(200, got, extra);
  endtask

  task automatic test_reset_mid_send();
    m_len = 40;
    req_data[15:8] = 8'h77; sb.push_back('{1, 8'h77}); req = 4'b0010;
    wait_ack(50, got);
    checks++; if (!got) begin errors++; $display("FAIL ms_wait: got none expected ack"); end
    if (got) begin
      e = sb.pop_front(); ea = '0; ea[e.id] = 1'b1;
      checks++; if (req_ack !== ea) begin errors++; $display("FAIL ms_ack: got %b expected %b", req_ack, ea); end
    end
    req = '0;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ms_in_send: got busy %b expected 1", busy); end
    req_data[7:0] = 8'h19; req = 4'b0011;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL ms_busy: got %b expected 0", busy); end
    checks++; if (frame_cnt !== 16'd0)  begin errors++; $display("FAIL ms_fcnt: got %0d expected 0", frame_cnt); end
    checks++; if (grant_id !== 2'd0)    begin errors++; $display("FAIL ms_gid: got %0d expected 0", grant_id); end
    checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL ms_data: got %h expected 00", tx_data); end
    #3 rst_n = 1'b1;
    sb.push_back('{0, 8'h19});
    wait_ack(200, got);
    checks++; if (!got) begin errors++; $display("FAIL ms_next_wait: got none expected ack"); end
    if (got) begin
      e = sb.pop_front(); ea = '0; ea[e.id] = 1'b1;
      checks++; if (req_ack !== ea)    begin errors++; $display("FAIL ms_next_ack: got %b expected %b", req_ack, ea); end
      checks++; if (tx_data !== e.dat) begin errors++; $display("FAIL ms_next_data: got %h expected %h", tx_data, e.dat); end
    end
    req = '0;
    wait_not_busy(200, got, extra);
  endtask

  task automatic test_wrap();
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    @(negedge clk);
    checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", frame_cnt); end
    m_len = 5;
    req_data[31:24] = 8'hE1; sb.push_back('{3, 8'hE1}); req = 4'b1000;
    wait_ack(50, got);
    checks++; if (!got) begin errors++; $display("FAIL wrap_wait: got none expected ack"); end
    if (got) begin
      e = sb.pop_front(); ea = '0; ea[e.id] = 1'b1;
      checks++; if (req_ack !== ea) begin errors++; $display("FAIL wrap_ack: got %b expected %b", req_ack, ea); end
    end
    req = '0;
    wait_not_busy(100, got, extra);
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_fcnt: got %h expected 0000", frame_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_busy_start();
    test_reset_mid_send();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
